// File: rtl/apb_pkg.sv
// apb_pkg: shared APB requester types
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_req_state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } apb_cmd_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_cmd_requester.sv
// apb_cmd_requester: valid/ready command stream to single APB transfers with timeout
module apb_cmd_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  apb_req_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic misaligned;
  assign misaligned = |(cmd_addr & ALIGN_MASK);
  // Request FSM; every output is a register updated on the transition that defines it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (misaligned) begin
              state_q     <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state_q <= SETUP;
              cnt_q   <= '0;
              psel    <= 1'b1;
              pwrite  <= cmd_write;
              paddr   <= cmd_addr;
              pprot   <= cmd_prot;
              pwdata  <= cmd_write ? cmd_wdata : '0;
              pstrb   <= cmd_write ? cmd_strb : '0;
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state_q     <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (pwrite || pslverr) ? '0 : prdata;
          end else if (TO_EN && cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(cnt_q != {CW{1'b1}});
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_requester.sv
// tb_apb_cmd_requester: randomized check of the APB requester against a transaction-level model
module tb_apb_cmd_requester;
  localparam int T = 4;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_strb = 0;
  logic [2:0] cmd_prot = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0] pstrb;
  logic [2:0] pprot;
  logic pready = 0, pslverr = 0;
  logic [31:0] prdata = 0;

  apb_cmd_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'hDEADBEEF : (32'h1234_5600 ^ (i * 32'h0101_0107));
  endfunction

  // Completer: word memory at paddr[9:2], region 0x300-0x3FF needs privileged prot[0]
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int acc = 0, wait_cfg = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc == wait_cfg);
      acc++;
    end else begin
      pready = 0;
      acc = 0;
    end
    pslverr = pready && paddr[9:8] == 2'b11 && !pprot[0];
    prdata = (pready && !pwrite) ? mem[paddr[9:2]] : $urandom;
  end
  always @(posedge clk)
    if (!reset && psel && penable && pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) mem[paddr[9:2]][b*8 +: 8] <= pwdata[b*8 +: 8];

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    logic ok, r;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      if (r) begin ok = 1; break; end
    end
    #1;
    cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = $urandom; cmd_prot = $urandom;
    chk("accept", ok, 1);
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p, input int waits, input int hold);
    logic mis, to, perr, err, seen;
    logic [31:0] erd, mask;
    int lat, pc, j, psc;
    mis  = a[1:0] != 0;
    to   = !mis && waits >= T;
    perr = !mis && !to && a[9:8] == 2'b11 && !p[0];
    err  = mis || to || perr;
    erd  = (err || w) ? 32'h0 : ref_mem[a[9:2]];
    lat  = mis ? 1 : to ? T + 2 : 3 + waits;
    pc   = mis ? 0 : to ? T + 1 : 2 + waits;
    if (w && !err) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~mask) | (d & mask);
    end
    wait_cfg = waits;
    issue(w, a, d, s, p);
    seen = 0; psc = 0;
    for (j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
      if (psel) begin
        psc++;
        chk("paddr", paddr, a);
        chk("pwrite", pwrite, w);
        chk("pprot", pprot, p);
        chk("pstrb", pstrb, w ? s : 4'h0);
        chk("pwdata", pwdata, w ? d : 32'h0);
        chk("penable", penable, psc > 1);
      end else chk("penable_idle", penable, 0);
    end
    chk("rsp_seen", seen, 1);
    chk("latency", j, lat);
    chk("psel_cycles", psc, pc);
    chk("rsp_err", rsp_err, err);
    chk("rsp_timeout", rsp_timeout, to);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("busy_ready", cmd_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, erd);
      chk("hold_err", rsp_err, err);
      chk("hold_timeout", rsp_timeout, to);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_psel", psel, 0);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    logic ok;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite,
                        pprot, pstrb}, 0);
    chk("rst_buses", {rsp_rdata, paddr | pwdata}, 0);
    reset = 0;
    chk("rst_ready_low", cmd_ready, 0);
    @(posedge clk);
    #1 chk("rst_ready_rise", cmd_ready, 1);

    run(0, 32'h04, 32'h0, 4'hF, 3'b000, 0, 0);
    chk("deadbeef", rsp_rdata === 32'h0 && ref_mem[1] == 32'hDEADBEEF, 1);
    run(1, 32'h84, 32'hFFFF_FFFF, 4'h1, 3'b000, 1, 0);
    run(0, 32'h84, 32'h0, 4'hF, 3'b000, 0, 0);
    chk("sparse_model", ref_mem[33], init_word(33) | 32'hFF);
    run(0, 32'h10, 32'h0, 4'hF, 3'b000, 3, 0);
    run(0, 32'h300, 32'h0, 4'hF, 3'b110, 0, 0);
    run(0, 32'h03, 32'h0, 4'hF, 3'b000, 0, 0);
    run(0, 32'h20, 32'h0, 4'hF, 3'b000, 7, 0);
    run(1, 32'h24, 32'h5555_AAAA, 4'hF, 3'b000, T, 0);
    run(1, 32'h28, 32'h1357_9BDF, 4'hC, 3'b000, T - 1, 0);
    run(0, 32'h28, 32'h0, 4'h0, 3'b000, 0, 0);
    run(1, 32'h88, 32'hCAFE_F00D, 4'hF, 3'b001, 0, 5);

    wait_cfg = 10;
    issue(0, 32'h40, 32'h0, 4'h0, 3'b001);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (psel && penable) begin ok = 1; break; end
    end
    chk("reach_access", ok, 1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_psel", {psel, penable}, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 0;
    chk("post_rst_low", cmd_ready, 0);
    @(posedge clk);
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_rsp", rsp_valid, 0);

    for (int n = 0; n < 150; n++) begin
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      run(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
          $urandom_range(0, 6), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
